// File: rtl/usr_shift_sequencer.sv
// Sequencer driving ctrl/d of a universal shift register: parallel load, then scale shifts, then a done pulse.
// Accept-to-done latency scale+2 cycles (+1 per stall cycle); in_ready only in IDLE, stall freezes SHIFT, flush aborts.
module usr_shift_sequencer #(
  parameter int scale = 8,
  parameter int CNT_W = $clog2(scale) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [scale-1:0] in_data,
  input  logic             in_dir,
  input  logic             serial_in,
  input  logic             stall,
  input  logic             flush,
  output logic             in_ready,
  output logic [1:0]       ctrl,
  output logic [scale-1:0] d,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [scale-1:0]   data_q, data_d;
  logic               dir_q, dir_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    dir_d     = dir_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d    = in_data;
          dir_d     = in_dir;
          bit_cnt_d = '0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (flush) begin
          bit_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // flush takes priority over stall
        if (flush) begin
          bit_cnt_d = '0;
          state_d   = IDLE;
        end else if (!stall) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(scale - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      data_q    <= '0;
      dir_q     <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      dir_q     <= dir_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // d tracks serial_in combinationally so the fill bit lands on the same edge as the shift
  always_comb begin
    ctrl = 2'b00;
    d    = '0;
    if (state_q == LOAD && !flush) begin
      ctrl = 2'b11;
      d    = data_q;
    end else if (state_q == SHIFT && !flush && !stall) begin
      if (dir_q) begin
        ctrl = 2'b10;
        d    = {serial_in, {(scale-1){1'b0}}};
      end else begin
        ctrl = 2'b01;
        d    = {{(scale-1){1'b0}}, serial_in};
      end
    end
  end

  assign in_ready = (state_q == IDLE) & reset_n;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign bit_cnt  = bit_cnt_q;

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Directed bench for usr_shift_sequencer with a behavioural downstream shift register fed by ctrl/d.
module tb_usr_shift_sequencer;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_dir;
  logic       serial_in;
  logic       stall;
  logic       flush;
  logic       in_ready;
  logic [1:0] ctrl;
  logic [7:0] d;
  logic       busy;
  logic       done;
  logic [3:0] bit_cnt;
  logic [7:0] sreg;

  int errors = 0;
  int checks = 0;

  usr_shift_sequencer #(.scale(8), .CNT_W(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_dir   (in_dir),
    .serial_in(serial_in),
    .stall    (stall),
    .flush    (flush),
    .in_ready (in_ready),
    .ctrl     (ctrl),
    .d        (d),
    .busy     (busy),
    .done     (done),
    .bit_cnt  (bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // downstream universal shift register
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) sreg <= 8'h00;
    else begin
      case (ctrl)
        2'b11:   sreg <= d;
        2'b01:   sreg <= {sreg[6:0], d[0]};
        2'b10:   sreg <= {d[7], sreg[7:1]};
        default: sreg <= sreg;
      endcase
    end
  end

  typedef struct {
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_dir;
    logic       serial_in;
    logic       stall;
    logic       flush;
    logic       exp_rdy;
    logic [1:0] exp_ctrl;
    logic [7:0] exp_d;
    logic       exp_busy;
    logic       exp_done;
    logic [3:0] exp_cnt;
    logic [7:0] exp_reg;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic v, input logic [7:0] dat, input logic dir, input logic si,
                     input logic st, input logic fl, input logic rdy, input logic [1:0] c,
                     input logic [7:0] dd, input logic b, input logic dn, input logic [3:0] cnt,
                     input logic [7:0] r);
    vec_t t;
    t.in_valid = v;   t.in_data = dat; t.in_dir = dir; t.serial_in = si;
    t.stall = st;     t.flush = fl;    t.exp_rdy = rdy; t.exp_ctrl = c;
    t.exp_d = dd;     t.exp_busy = b;  t.exp_done = dn; t.exp_cnt = cnt;
    t.exp_reg = r;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    in_valid = 1'b0; in_data = 8'h00; in_dir = 1'b0;
    serial_in = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  logic [7:0] lreg [0:8];
  logic [7:0] rreg [0:8];

  initial begin
    int done_at;
    int done_cnt;
    int gap;
    int rdy_low;
    int acc[$];
    logic [7:0] loads[$];

    reset_n = 1'b0;
    idle_inputs();

    lreg = '{8'hA5, 8'h4A, 8'h94, 8'h28, 8'h50, 8'hA0, 8'h40, 8'h80, 8'h00};
    rreg = '{8'h81, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'hFF};

    // left word 0xA5, fill 0
    add(1, 8'hA5, 0, 0, 0, 0, 1, 2'b00, 8'h00, 0, 0, 4'd0, 8'h00);
    add(0, 8'h00, 0, 0, 0, 0, 0, 2'b11, 8'hA5, 1, 0, 4'd0, 8'h00);
    for (int k = 0; k < 8; k++)
      add(0, 8'h00, 0, 0, 0, 0, 0, 2'b01, 8'h00, 1, 0, 4'(k), lreg[k]);
    add(0, 8'h00, 0, 0, 0, 0, 0, 2'b00, 8'h00, 1, 1, 4'd8, lreg[8]);
    add(0, 8'h00, 0, 0, 0, 0, 1, 2'b00, 8'h00, 0, 0, 4'd8, lreg[8]);
    // right word 0x81, fill 1 throughout (d must stay 0 outside SHIFT)
    add(1, 8'h81, 1, 1, 0, 0, 1, 2'b00, 8'h00, 0, 0, 4'd8, 8'h00);
    add(0, 8'h00, 0, 1, 0, 0, 0, 2'b11, 8'h81, 1, 0, 4'd0, 8'h00);
    for (int k = 0; k < 8; k++)
      add(0, 8'h00, 0, 1, 0, 0, 0, 2'b10, 8'h80, 1, 0, 4'(k), rreg[k]);
    add(0, 8'h00, 0, 1, 0, 0, 0, 2'b00, 8'h00, 1, 1, 4'd8, rreg[8]);
    add(0, 8'h00, 0, 1, 1, 1, 1, 2'b00, 8'h00, 0, 0, 4'd8, rreg[8]);

    @(negedge clk);
    chk("reset_outputs", {in_ready, ctrl, d, busy, done, bit_cnt}, 17'h0);
    step();
    reset_n = 1'b1;
    #1;
    chk("reset_release_ready", in_ready, 1'b1);

    for (int i = 0; i < vq.size(); i++) begin
      in_valid = vq[i].in_valid; in_data = vq[i].in_data; in_dir = vq[i].in_dir;
      serial_in = vq[i].serial_in; stall = vq[i].stall; flush = vq[i].flush;
      @(negedge clk);
      chk($sformatf("vec%0d_outs", i), {in_ready, ctrl, d, busy, done, bit_cnt},
          {vq[i].exp_rdy, vq[i].exp_ctrl, vq[i].exp_d, vq[i].exp_busy, vq[i].exp_done, vq[i].exp_cnt});
      chk($sformatf("vec%0d_reg", i), sreg, vq[i].exp_reg);
      step();
    end
    idle_inputs();

    // stall for 3 cycles after the 2nd shift
    in_valid = 1'b1; in_data = 8'h3C;
    @(negedge clk);
    chk("stall_accept", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    done_at = -1;
    for (int c = 1; c <= 30 && done_at < 0; c++) begin
      stall = (c >= 4 && c <= 6);
      @(negedge clk);
      if (c >= 4 && c <= 6) begin
        chk($sformatf("stall_ctrl_c%0d", c), ctrl, 2'b00);
        chk($sformatf("stall_cnt_c%0d", c), bit_cnt, 4'd2);
      end
      if (c == 7) chk("stall_reg_mid", sreg, 8'hF0);
      if (done) begin
        done_at = c;
        chk("stall_reg_final", sreg, 8'h00);
        chk("stall_cnt_done", bit_cnt, 4'd8);
      end
      step();
    end
    stall = 1'b0;
    chk("stall_latency", done_at, 13);

    // flush on the 4th SHIFT cycle
    in_valid = 1'b1; in_data = 8'hA5; in_dir = 1'b0;
    @(negedge clk);
    step();
    in_valid = 1'b0;
    done_cnt = 0;
    for (int c = 1; c <= 15; c++) begin
      flush = (c == 5);
      @(negedge clk);
      if (done) done_cnt++;
      if (c == 5) begin
        chk("flush_ctrl", ctrl, 2'b00);
        chk("flush_d", d, 8'h00);
        chk("flush_reg", sreg, 8'h28);
      end
      if (c == 6) begin
        chk("flush_idle", {in_ready, busy, bit_cnt}, {1'b1, 1'b0, 4'd0});
        chk("flush_reg_hold", sreg, 8'h28);
      end
      step();
    end
    flush = 1'b0;
    chk("flush_no_done", done_cnt, 0);

    // back-to-back with in_valid held high
    in_valid = 1'b1; in_data = 8'h11;
    rdy_low = 0;
    for (int c = 0; c < 40 && acc.size() < 2; c++) begin
      @(negedge clk);
      if (in_ready) acc.push_back(c);
      else if (acc.size() == 1) rdy_low++;
      if (ctrl == 2'b11) loads.push_back(d);
      step();
      if (acc.size() == 1) in_data = 8'h22;
    end
    in_valid = 1'b0;
    done_at = -1;
    for (int c = 0; c < 20 && done_at < 0; c++) begin
      @(negedge clk);
      if (ctrl == 2'b11) loads.push_back(d);
      if (done) done_at = c;
      step();
    end
    chk("b2b_accepts", acc.size(), 2);
    gap = (acc.size() == 2) ? acc[1] - acc[0] : -1;
    chk("b2b_gap", gap, 11);
    chk("b2b_ready_low", rdy_low, 10);
    chk("b2b_load0", (loads.size() > 0) ? loads[0] : 8'hxx, 8'h11);
    chk("b2b_load1", (loads.size() > 1) ? loads[1] : 8'hxx, 8'h22);
    chk("b2b_second_done", (done_at >= 0), 1'b1);
    chk("b2b_reg", sreg, 8'h00);

    // async reset in the middle of SHIFT
    in_valid = 1'b1; in_data = 8'h33;
    @(negedge clk);
    step();
    in_valid = 1'b0;
    for (int c = 1; c < 4; c++) step();
    @(negedge clk);
    chk("pre_reset_shifting", ctrl, 2'b01);
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_outs", {ctrl, busy, done, bit_cnt, in_ready}, 9'h0);
    step();
    step();
    reset_n = 1'b1;
    #1;
    chk("areset_ready", {in_ready, busy}, 2'b10);

    // normal 0x5A transaction afterwards, left with fill 1
    in_valid = 1'b1; in_data = 8'h5A; serial_in = 1'b1;
    @(negedge clk);
    step();
    in_valid = 1'b0;
    done_at = -1;
    for (int c = 1; c <= 30 && done_at < 0; c++) begin
      @(negedge clk);
      if (c == 2) chk("post_load_reg", sreg, 8'h5A);
      if (c == 3) chk("post_shift_d", {ctrl, d}, {2'b01, 8'h01});
      if (done) begin
        done_at = c;
        chk("post_cnt", bit_cnt, 4'd8);
        chk("post_reg", sreg, 8'hFF);
      end
      step();
    end
    chk("post_latency", done_at, 10);
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
